// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with 3-sample majority vote,
// start-glitch rejection, framing-error pulse and a FWFT byte FIFO.
module uart_rx_buffered #(
    parameter int WAIT  = 234,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     uart_rx,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     frame_err,
    output logic                     overrun,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(WAIT);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] C_LO  = CW'(WAIT / 2 - 1);
    localparam logic [CW-1:0] C_MID = CW'(WAIT / 2);
    localparam logic [CW-1:0] C_DEC = CW'(WAIT / 2 + 1);
    localparam logic [CW-1:0] C_END = CW'(WAIT - 1);
    localparam logic [AW:0]   C_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_WAIT_HIGH,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit;
    logic            r_s0;
    logic            r_s1;
    logic [7:0]      r_shift;
    logic            r_ferr;
    logic            r_ovr;
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [7:0]      r_mem [DEPTH];

    logic            w_maj;
    logic            w_decide;
    logic            w_bit_end;
    logic            w_cnt_clr;
    logic            w_shift;
    logic            w_good;
    logic            w_bad;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic [AW:0]     w_count;

    assign w_maj     = (r_s0 & r_s1) | (r_s0 & uart_rx) | (r_s1 & uart_rx);
    assign w_decide  = (r_cnt == C_DEC);
    assign w_bit_end = (r_cnt == C_END);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT_HIGH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle frame events
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        unique case (r_state)
            S_WAIT_HIGH: begin
                if (uart_rx) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!uart_rx) begin
                    w_state_nxt = S_START;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_START: begin
                if (w_decide && w_maj) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_shift = w_decide;
                if (w_bit_end && (r_bit == 3'd7)) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_decide) begin
                    if (w_maj) begin
                        w_good      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_bad       = 1'b1;
                        w_state_nxt = S_WAIT_HIGH;
                    end
                end
            end
            default: begin
                w_state_nxt = S_WAIT_HIGH;
            end
        endcase
    end

    // Bit-time counter, data bit index, vote samples and shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
            r_shift <= '0;
        end else begin
            if (w_cnt_clr || w_bit_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_cnt_clr) begin
                r_bit <= '0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_bit <= r_bit + 3'd1;
            end
            if (r_cnt == C_LO) begin
                r_s0 <= uart_rx;
            end
            if (r_cnt == C_MID) begin
                r_s1 <= uart_rx;
            end
            if (w_shift) begin
                r_shift <= {w_maj, r_shift[7:1]};
            end
        end
    end

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == C_FULL);
    assign w_pop   = rx_valid & rx_ready;
    assign w_push  = w_good & (~w_full | w_pop);

    // FIFO pointers and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
            end
            r_ferr <= w_bad;
            if (w_good && w_full && !w_pop) begin
                r_ovr <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        end
    end

    assign count     = w_count;
    assign rx_valid  = (w_count != '0);
    assign rx_data   = rx_valid ? r_mem[r_rd_ptr[AW-1:0]] : 8'h00;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed bench for uart_rx_buffered with
// WAIT=8, DEPTH=4; inputs driven 1 after posedge, outputs sampled at negedge.
module tb_uart_rx_buffered;

    localparam int W = 8;

    logic       clk;
    logic       reset;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int ferr_before;

    uart_rx_buffered #(.WAIT(W), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles in which frame_err is high
    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        @(negedge clk);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start bit plus 8 data bits, W cycles each
    task automatic send_head(input logic [7:0] b);
        uart_rx = 1'b0;
        tick(W);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(W);
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_head(b);
        uart_rx = 1'b1;
        tick(W);
    endtask

    task automatic pop1;
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick(2);

        // 0x55 with latency check, then 0xA3 back-to-back
        send_head(8'h55);
        uart_rx = 1'b1;
        tick(6);
        check("lat_t78_valid", 32'(rx_valid), 32'd0);
        tick(1);
        check("lat_t79_valid", 32'(rx_valid), 32'd1);
        check("lat_t79_data", 32'(rx_data), 32'h55);
        check("lat_t79_count", 32'(count), 32'd1);
        tick(1);
        send_frame(8'hA3);
        check("b2b_count", 32'(count), 32'd2);
        check("b2b_head", 32'(rx_data), 32'h55);
        rx_ready = 1'b1;
        tick(1);
        check("pop1_data", 32'(rx_data), 32'hA3);
        check("pop1_count", 32'(count), 32'd1);
        tick(1);
        rx_ready = 1'b0;
        check("pop2_valid", 32'(rx_valid), 32'd0);
        check("pop2_count", 32'(count), 32'd0);

        // Start-bit glitch of 2 cycles
        uart_rx = 1'b0;
        tick(2);
        uart_rx = 1'b1;
        tick(12);
        check("glitch_count", 32'(count), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt), 32'd0);
        send_frame(8'h0F);
        check("after_glitch_count", 32'(count), 32'd1);
        check("after_glitch_data", 32'(rx_data), 32'h0F);
        pop1();

        // 0x00 with a one-cycle high at the middle sample of data bit 3
        uart_rx = 1'b0;
        tick(37);
        uart_rx = 1'b1;
        tick(1);
        uart_rx = 1'b0;
        tick(34);
        uart_rx = 1'b1;
        tick(W);
        check("vote_count", 32'(count), 32'd1);
        check("vote_data", 32'(rx_data), 32'h00);
        pop1();

        // 0x81 with the stop bit held low for two bit times
        ferr_before = ferr_cnt;
        send_head(8'h81);
        uart_rx = 1'b0;
        tick(2 * W);
        uart_rx = 1'b1;
        tick(W);
        check("ferr_pulses", 32'(ferr_cnt - ferr_before), 32'd1);
        check("ferr_count", 32'(count), 32'd0);
        send_frame(8'h42);
        check("post_ferr_count", 32'(count), 32'd1);
        check("post_ferr_data", 32'(rx_data), 32'h42);
        pop1();

        // Overflow: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i));
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_flag", 32'(overrun), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_read", 32'(rx_data), 32'(i));
            pop1();
        end
        check("ovf_drained", 32'(rx_valid), 32'd0);
        check("ovf_sticky", 32'(overrun), 32'd1);

        reset = 1'b1;
        tick(2);
        check("rst2_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick(2);

        // Same, but a pop coincides with the push of byte 5
        for (int i = 1; i <= 4; i++) send_frame(8'(i));
        send_head(8'h05);
        uart_rx = 1'b1;
        tick(6);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(1);
        check("pp_count", 32'(count), 32'd4);
        check("pp_ovr", 32'(overrun), 32'd0);
        for (int i = 2; i <= 5; i++) begin
            check("pp_read", 32'(rx_data), 32'(i));
            pop1();
        end
        check("pp_drained", 32'(count), 32'd0);

        // Reset mid-DATA with the line held low
        send_frame(8'h11);
        check("pre_rst_count", 32'(count), 32'd1);
        ferr_before = ferr_cnt;
        uart_rx = 1'b0;
        tick(30);
        reset = 1'b1;
        tick(2);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_data", 32'(rx_data), 32'h00);
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        reset = 1'b0;
        tick(100);
        check("low_hold_count", 32'(count), 32'd0);
        check("low_hold_ferr", 32'(ferr_cnt - ferr_before), 32'd0);
        check("low_hold_ovr", 32'(overrun), 32'd0);
        uart_rx = 1'b1;
        tick(3);
        send_frame(8'h3C);
        check("fresh_count", 32'(count), 32'd1);
        check("fresh_data", 32'(rx_data), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Buffered UART receive front-end that consumes the two-flop-synchronized `uart_rx` line from the board top and hands bytes to the mother board over a ready/valid interface. It samples each bit three times around mid-bit with majority voting, rejects start-bit glitches, and flags framing errors. Received bytes are queued in a small FIFO so that software polling latency does not drop characters.

## Interface
- `WAIT`, default 234: clock cycles per bit (CLOCK_HZ/UART_BAUD_RATE); legal range ≥ 8.
- `DEPTH`, default 16: FIFO entries; must be a power of two, ≥ 2.
- `clk`  input  1  system clock (27 MHz on Tang Nano 9K).
- `reset`  input  1  synchronous, active-high reset.
- `uart_rx`  input  1  already-synchronized serial line; idles high. Frame is 8N1, LSB first.
- `rx_data`  output  8  FIFO head byte; valid only while `rx_valid`.
- `rx_valid`  output  1  FIFO not empty.
- `rx_ready`  input  1  consumer accepts the head byte on a cycle where `rx_valid & rx_ready`.
- `frame_err`  output  1  one-cycle pulse when a stop bit samples low.
- `overrun`  output  1  sticky; set when a good byte arrives while the FIFO is full; cleared only by reset.
- `count`  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- States: WAIT_HIGH, IDLE, START, DATA, STOP.
- Reset enters WAIT_HIGH. The FIFO is emptied, and all outputs are 0 (`rx_data` = 0x00, `count` = 0).
- WAIT_HIGH: stay until `uart_rx` = 1, then go to IDLE. This prevents a line held low at reset release from being taken as a start bit.
- IDLE: on the first cycle t0 with `uart_rx` = 0, go to START and clear bit counter `cnt`. `cnt` = 0 in cycle t0+1 and increments every cycle.
- Each bit spans `cnt` = 0..WAIT-1, then `cnt` returns to 0 for the next bit.
  - Samples are taken at `cnt` = WAIT/2-1, WAIT/2, WAIT/2+1 (integer division).
  - The bit value is the majority of the 3 samples, decided at `cnt` = WAIT/2+1.
- START: if the majority is 1, the start is false; return to IDLE at the decision cycle with no other effect. Otherwise go to DATA at `cnt` = WAIT-1.
- DATA: 8 bits, shifted in LSB first. After bit 7 ends, go to STOP.
- STOP: decided at `cnt` = WAIT/2+1, and the state leaves STOP in that same cycle.
  - Majority 1: push the byte, or set `overrun` and drop the byte if the FIFO is full and no pop occurs that cycle. Go to IDLE. Entering IDLE mid-stop-bit allows back-to-back frames.
  - Majority 0: pulse `frame_err` in the following cycle, discard the byte, and go to WAIT_HIGH.
- FIFO behaviour:
  - First-word fall-through; `rx_data` is the head entry.
  - Pointers wrap modulo DEPTH.
  - `count` = write pointer − read pointer, computed with one extra wrap bit.
- FIFO boundary rules:
  - Pop when empty: ignored.
  - Push and pop in the same cycle, any occupancy (including full): both occur, `count` unchanged, no overrun.
  - Push while full without a pop: data dropped, `overrun` set, `count` stays DEPTH.
- Reset mid-frame: frame abandoned, FIFO cleared, flags cleared, state WAIT_HIGH.

## Timing
- Push is registered at the end of cycle t0+1+9·WAIT+WAIT/2+1. `rx_valid`, `rx_data` and `count` reflect it in cycle t0+9·WAIT+WAIT/2+3.
- Pop: on a cycle with `rx_valid & rx_ready`, the next head appears on `rx_data` (or `rx_valid` falls) in the following cycle.
- `frame_err` is high for exactly one cycle: the cycle after the STOP decision.
- `overrun` rises in the cycle after the dropped push and stays high until reset.
- No combinational path from `rx_ready` to any output.

## Test plan
- Setup for all cases: WAIT=8, DEPTH=4, unless noted otherwise.
- Send 0x55 then 0xA3 back-to-back with `rx_ready`=0.
  - Expect `rx_valid` at t0+9·8+4+3 = t0+79, with `rx_data`=0x55 and `count` going 1 then 2.
  - With `rx_ready` held 1: 0x55 then 0xA3 are popped in order, then `rx_valid`=0.
- Glitch: line low for 2 cycles, then high.
  - Expect no push, no `frame_err`, state back in IDLE.
  - A following 0x0F frame is received correctly.
- Single-cycle glitch at the mid-bit sample of data bit 3 in 0x00: majority vote yields 0x00.
- Frame 0x81 with the stop bit held low for 2 bit times.
  - Expect a `frame_err` pulse of 1 cycle and `count` remaining 0.
  - Nothing is received until the line returns high; the next 0x42 is received.
- Send 5 bytes 0x01..0x05 with `rx_ready`=0.
  - Expect `count`=4, `overrun`=1 after byte 5, and reads yielding 0x01..0x04.
  - Repeat with `rx_ready` pulsed in the push cycle of byte 5: no overrun, `count` stays 4.
- Assert `reset` in the middle of DATA with the line held low; release `reset`.
  - Expect all outputs 0 and no byte until the line goes high and a fresh frame 0x3C completes.
